// File: rtl/mmss_pkg.sv
// Shared types, digit-select codes and limits for the MM:SS timer.
// The clamp function keeps loaded digits inside their legal BCD range.
package mmss_pkg;

  typedef logic [3:0] bcd_t;

  localparam logic [1:0] SEL_MIN_L = 2'd0;
  localparam logic [1:0] SEL_MIN_R = 2'd1;
  localparam logic [1:0] SEL_SEC_L = 2'd2;
  localparam logic [1:0] SEL_SEC_R = 2'd3;

  localparam bcd_t SEC_L_MAX = 4'd5;
  localparam bcd_t DIGIT_MAX = 4'd9;

  function automatic bcd_t clamp_digit(input logic [1:0] sel, input bcd_t val);
    bcd_t lim_v;
    if (sel == SEL_SEC_L) begin
      lim_v = SEC_L_MAX;
    end else begin
      lim_v = DIGIT_MAX;
    end
    return (val > lim_v) ? lim_v : val;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running 0..DIV-1 divider that holds while disabled; step is
// asserted during the terminal count so the consumer updates on that edge.
module tick_prescaler #(
  parameter int DIV = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic step
);

  localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);
  localparam logic [CW-1:0] ZERO = CW'(0);

  logic [CW-1:0] cnt_r;

  assign step = en && (cnt_r == LAST);

  // Divider count: clear wins, otherwise advance and roll only while enabled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= ZERO;
    end else if (clr) begin
      cnt_r <= ZERO;
    end else if (en) begin
      if (cnt_r == LAST) begin
        cnt_r <= ZERO;
      end else begin
        cnt_r <= cnt_r + ONE;
      end
    end else begin
      cnt_r <= cnt_r;
    end
  end

endmodule

// File: rtl/mmss_timer.sv
// BCD MM:SS up/down timer with pause, per-digit load and clear.
// All outputs are registered; status pulses coincide with the digit update.
module mmss_timer
  import mmss_pkg::*;
#(
  parameter int CLK_HZ  = 100_000_000,
  parameter int TICK_HZ = 1,
  parameter int WRAP    = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       run,
  input  logic       dir,
  input  logic       ld,
  input  logic [1:0] ld_sel,
  input  logic [3:0] ld_val,
  output logic [3:0] min_l,
  output logic [3:0] min_r,
  output logic [3:0] sec_l,
  output logic [3:0] sec_r,
  output logic       tick,
  output logic       zero,
  output logic       done,
  output logic       ovf
);

  localparam int DIV = CLK_HZ / TICK_HZ;

  bcd_t min_l_r, min_r_r, sec_l_r, sec_r_r;
  bcd_t min_l_s, min_r_s, sec_l_s, sec_r_s;
  logic tick_r, zero_r, done_r, ovf_r;
  logic tick_s, done_s, ovf_s;
  logic step_s, at_max_s, at_zero_s, nxt_zero_s;

  tick_prescaler #(.DIV(DIV)) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr),
    .en   (run),
    .step (step_s)
  );

  assign at_max_s  = (min_l_r == DIGIT_MAX) && (min_r_r == DIGIT_MAX) &&
                     (sec_l_r == SEC_L_MAX) && (sec_r_r == DIGIT_MAX);
  assign at_zero_s = (min_l_r == 4'd0) && (min_r_r == 4'd0) &&
                     (sec_l_r == 4'd0) && (sec_r_r == 4'd0);
  assign nxt_zero_s = (min_l_s == 4'd0) && (min_r_s == 4'd0) &&
                      (sec_l_s == 4'd0) && (sec_r_s == 4'd0);

  // Next digits and pulses; priority is clear, then load, then count step.
  always_comb begin
    min_l_s = min_l_r;
    min_r_s = min_r_r;
    sec_l_s = sec_l_r;
    sec_r_s = sec_r_r;
    tick_s  = 1'b0;
    done_s  = 1'b0;
    ovf_s   = 1'b0;
    if (clr) begin
      min_l_s = 4'd0;
      min_r_s = 4'd0;
      sec_l_s = 4'd0;
      sec_r_s = 4'd0;
    end else if (ld) begin
      case (ld_sel)
        SEL_MIN_L: min_l_s = clamp_digit(ld_sel, ld_val);
        SEL_MIN_R: min_r_s = clamp_digit(ld_sel, ld_val);
        SEL_SEC_L: sec_l_s = clamp_digit(ld_sel, ld_val);
        SEL_SEC_R: sec_r_s = clamp_digit(ld_sel, ld_val);
        default:   min_l_s = min_l_r;
      endcase
    end else if (step_s && !dir) begin
      tick_s = 1'b1;
      if (at_max_s) begin
        ovf_s = 1'b1;
        if (WRAP != 0) begin
          min_l_s = 4'd0;
          min_r_s = 4'd0;
          sec_l_s = 4'd0;
          sec_r_s = 4'd0;
        end else begin
          min_l_s = min_l_r;
        end
      end else if (sec_r_r != DIGIT_MAX) begin
        sec_r_s = sec_r_r + 4'd1;
      end else begin
        sec_r_s = 4'd0;
        if (sec_l_r != SEC_L_MAX) begin
          sec_l_s = sec_l_r + 4'd1;
        end else begin
          sec_l_s = 4'd0;
          if (min_r_r != DIGIT_MAX) begin
            min_r_s = min_r_r + 4'd1;
          end else begin
            min_r_s = 4'd0;
            min_l_s = min_l_r + 4'd1;
          end
        end
      end
    end else if (step_s && dir && !at_zero_s) begin
      tick_s = 1'b1;
      if (sec_r_r != 4'd0) begin
        sec_r_s = sec_r_r - 4'd1;
      end else begin
        sec_r_s = DIGIT_MAX;
        if (sec_l_r != 4'd0) begin
          sec_l_s = sec_l_r - 4'd1;
        end else begin
          sec_l_s = SEC_L_MAX;
          if (min_r_r != 4'd0) begin
            min_r_s = min_r_r - 4'd1;
          end else begin
            min_r_s = DIGIT_MAX;
            min_l_s = min_l_r - 4'd1;
          end
        end
      end
      done_s = nxt_zero_s;
    end else begin
      min_l_s = min_l_r;
    end
  end

  // Registered digits and status so nothing reaches the outputs combinationally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      min_l_r <= 4'd0;
      min_r_r <= 4'd0;
      sec_l_r <= 4'd0;
      sec_r_r <= 4'd0;
      tick_r  <= 1'b0;
      done_r  <= 1'b0;
      ovf_r   <= 1'b0;
      zero_r  <= 1'b1;
    end else begin
      min_l_r <= min_l_s;
      min_r_r <= min_r_s;
      sec_l_r <= sec_l_s;
      sec_r_r <= sec_r_s;
      tick_r  <= tick_s;
      done_r  <= done_s;
      ovf_r   <= ovf_s;
      zero_r  <= nxt_zero_s;
    end
  end

  assign min_l = min_l_r;
  assign min_r = min_r_r;
  assign sec_l = sec_l_r;
  assign sec_r = sec_r_r;
  assign tick  = tick_r;
  assign zero  = zero_r;
  assign done  = done_r;
  assign ovf   = ovf_r;

endmodule

// File: tb/tb_mmss_timer.sv
// Directed bench for mmss_timer with DIV=10; a wrapping and a saturating
// instance share every input so boundary behaviour can be compared side by side.
module tb_mmss_timer;

  logic clk = 1'b0;
  logic rst, clr, run, dir, ld;
  logic [1:0] ld_sel;
  logic [3:0] ld_val;

  logic [3:0] a_ml, a_mr, a_sl, a_sr;
  logic a_tick, a_zero, a_done, a_ovf;
  logic [3:0] b_ml, b_mr, b_sl, b_sr;
  logic b_tick, b_zero, b_done, b_ovf;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  mmss_timer #(.CLK_HZ(10), .TICK_HZ(1), .WRAP(1)) u_dut (
    .clk(clk), .rst(rst), .clr(clr), .run(run), .dir(dir), .ld(ld),
    .ld_sel(ld_sel), .ld_val(ld_val),
    .min_l(a_ml), .min_r(a_mr), .sec_l(a_sl), .sec_r(a_sr),
    .tick(a_tick), .zero(a_zero), .done(a_done), .ovf(a_ovf)
  );

  mmss_timer #(.CLK_HZ(10), .TICK_HZ(1), .WRAP(0)) u_sat (
    .clk(clk), .rst(rst), .clr(clr), .run(run), .dir(dir), .ld(ld),
    .ld_sel(ld_sel), .ld_val(ld_val),
    .min_l(b_ml), .min_r(b_mr), .sec_l(b_sl), .sec_r(b_sr),
    .tick(b_tick), .zero(b_zero), .done(b_done), .ovf(b_ovf)
  );

  wire [15:0] a_time = {a_ml, a_mr, a_sl, a_sr};
  wire [15:0] b_time = {b_ml, b_mr, b_sl, b_sr};

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic load_digit(input logic [1:0] sel, input logic [3:0] val);
    ld = 1'b1; ld_sel = sel; ld_val = val;
    cyc(1);
    ld = 1'b0;
  endtask

  task automatic load_time(input logic [15:0] t);
    load_digit(2'd0, t[15:12]);
    load_digit(2'd1, t[11:8]);
    load_digit(2'd2, t[7:4]);
    load_digit(2'd3, t[3:0]);
  endtask

  task automatic do_clr();
    run = 1'b0; clr = 1'b1;
    cyc(1);
    clr = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; clr = 1'b0; run = 1'b0; dir = 1'b0; ld = 1'b0;
    ld_sel = 2'd0; ld_val = 4'd0;
    cyc(3);
    total++;
    if (a_time !== 16'h0000 || b_time !== 16'h0000) begin
      bad++; $display("FAIL reset_digits: got %h/%h want 0000", a_time, b_time);
    end
    total++;
    if ({a_zero, a_tick, a_done, a_ovf} !== 4'b1000) begin
      bad++; $display("FAIL reset_flags: got %b want 1000", {a_zero, a_tick, a_done, a_ovf});
    end
    rst = 1'b0;
    cyc(1);
  endtask

  task automatic test_count_up();
    int ticks = 0;
    int late = 0;
    run = 1'b1; dir = 1'b0;
    for (int i = 0; i < 600; i++) begin
      cyc(1);
      if (a_tick === 1'b1) ticks++;
      if (a_tick !== ((i % 10) == 9)) late++;
      if (i == 9) begin
        total++;
        if (a_time !== 16'h0001) begin
          bad++; $display("FAIL first_step: got %h want 0001", a_time);
        end
      end
    end
    run = 1'b0;
    total++;
    if (a_time !== 16'h0100) begin
      bad++; $display("FAIL up_600: got %h want 0100", a_time);
    end
    total++;
    if (ticks !== 60 || late !== 0) begin
      bad++; $display("FAIL up_ticks: got %0d (misplaced %0d) want 60 (0)", ticks, late);
    end
  endtask

  task automatic test_wrap();
    int a_ovfs = 0;
    int b_ovfs = 0;
    do_clr();
    load_time(16'h9959);
    dir = 1'b0; run = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cyc(1);
      if (a_ovf === 1'b1) a_ovfs++;
      if (b_ovf === 1'b1) b_ovfs++;
    end
    run = 1'b0;
    total++;
    if (a_time !== 16'h0000 || a_zero !== 1'b1 || a_ovfs !== 1 || a_tick !== 1'b1) begin
      bad++; $display("FAIL wrap: got %h zero=%b ovfs=%0d tick=%b want 0000 1 1 1",
                      a_time, a_zero, a_ovfs, a_tick);
    end
    total++;
    if (b_time !== 16'h9959 || b_zero !== 1'b0 || b_ovfs !== 1 || b_tick !== 1'b1) begin
      bad++; $display("FAIL saturate: got %h zero=%b ovfs=%0d tick=%b want 9959 0 1 1",
                      b_time, b_zero, b_ovfs, b_tick);
    end
  endtask

  task automatic test_countdown();
    int dones = 0;
    int ticks = 0;
    do_clr();
    load_time(16'h0002);
    total++;
    if (a_time !== 16'h0002 || a_zero !== 1'b0) begin
      bad++; $display("FAIL load_0002: got %h zero=%b want 0002 0", a_time, a_zero);
    end
    dir = 1'b1; run = 1'b1;
    for (int i = 0; i < 30; i++) begin
      cyc(1);
      if (a_done === 1'b1) dones++;
      if (a_tick === 1'b1) ticks++;
      if (i == 9) begin
        total++;
        if (a_time !== 16'h0001 || a_done !== 1'b0) begin
          bad++; $display("FAIL down_1: got %h done=%b want 0001 0", a_time, a_done);
        end
      end
      if (i == 19) begin
        total++;
        if (a_time !== 16'h0000 || a_done !== 1'b1 || a_tick !== 1'b1) begin
          bad++; $display("FAIL down_0: got %h done=%b tick=%b want 0000 1 1",
                          a_time, a_done, a_tick);
        end
      end
      if (i == 29) begin
        total++;
        if (a_tick !== 1'b0 || a_done !== 1'b0 || a_zero !== 1'b1) begin
          bad++; $display("FAIL hold_0: got tick=%b done=%b zero=%b want 0 0 1",
                          a_tick, a_done, a_zero);
        end
      end
    end
    run = 1'b0;
    total++;
    if (dones !== 1 || ticks !== 2) begin
      bad++; $display("FAIL down_counts: got done=%0d tick=%0d want 1 2", dones, ticks);
    end
  endtask

  task automatic test_pause();
    int moved = 0;
    int wait_n = 0;
    do_clr();
    load_digit(2'd3, 4'd3);
    dir = 1'b0; run = 1'b1;
    cyc(4);
    run = 1'b0;
    for (int i = 0; i < 50; i++) begin
      cyc(1);
      if (a_time !== 16'h0003 || a_tick !== 1'b0) moved++;
    end
    total++;
    if (moved !== 0) begin
      bad++; $display("FAIL pause_frozen: got %0d changed cycles want 0", moved);
    end
    run = 1'b1;
    while (a_tick !== 1'b1 && wait_n < 20) begin
      cyc(1);
      wait_n++;
    end
    run = 1'b0;
    total++;
    if (wait_n !== 6 || a_time !== 16'h0004) begin
      bad++; $display("FAIL resume: got %0d clocks time %h want 6 0004", wait_n, a_time);
    end
  endtask

  task automatic test_load_clamp();
    do_clr();
    load_digit(2'd2, 4'd8);
    load_digit(2'd0, 4'd12);
    load_digit(2'd1, 4'd15);
    load_digit(2'd3, 4'd7);
    total++;
    if (a_time !== 16'h9957) begin
      bad++; $display("FAIL clamp: got %h want 9957", a_time);
    end
  endtask

  task automatic test_ld_collision();
    int ticks = 0;
    do_clr();
    dir = 1'b0; run = 1'b1;
    cyc(9);
    ld = 1'b1; ld_sel = 2'd3; ld_val = 4'd4;
    cyc(1);
    ld = 1'b0;
    total++;
    if (a_time !== 16'h0004 || a_tick !== 1'b0) begin
      bad++; $display("FAIL ld_wins: got %h tick=%b want 0004 0", a_time, a_tick);
    end
    for (int i = 0; i < 9; i++) begin
      cyc(1);
      if (a_tick === 1'b1) ticks++;
    end
    cyc(1);
    run = 1'b0;
    total++;
    if (ticks !== 0 || a_tick !== 1'b1 || a_time !== 16'h0005) begin
      bad++; $display("FAIL ld_roll: got early=%0d tick=%b time %h want 0 1 0005",
                      ticks, a_tick, a_time);
    end
  endtask

  task automatic test_async_rst();
    do_clr();
    load_time(16'h1234);
    run = 1'b1;
    cyc(5);
    #2 rst = 1'b1;
    #1;
    total++;
    if (a_time !== 16'h0000 || a_zero !== 1'b1) begin
      bad++; $display("FAIL async_rst: got %h zero=%b want 0000 1", a_time, a_zero);
    end
    run = 1'b0;
    #1 rst = 1'b0;
    cyc(1);
  endtask

  task automatic test_clr();
    load_time(16'h0500);
    dir = 1'b1;
    do_clr();
    total++;
    if (a_time !== 16'h0000 || a_done !== 1'b0 || a_zero !== 1'b1 || a_tick !== 1'b0) begin
      bad++; $display("FAIL clr: got %h done=%b zero=%b tick=%b want 0000 0 1 0",
                      a_time, a_done, a_zero, a_tick);
    end
  endtask

  initial begin
    test_reset();
    test_count_up();
    test_wrap();
    test_countdown();
    test_pause();
    test_load_clamp();
    test_ld_collision();
    test_async_rst();
    test_clr();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mmss_timer.md
Name: mmss_timer

Overview:
- Parametrised successor to the stopwatch counter: BCD MM:SS time base that counts up (stopwatch) or down (countdown), with pause, per-digit load, synchronous clear, and defined 99:59 / 00:00 boundary behaviour.
- Sits between the clock divider and the 7-segment display driver.
- Contains its own tick prescaler and emits status pulses for LEDs or a buzzer.

Parameters:
- CLK_HZ, 100_000_000, input clock frequency.
- TICK_HZ, 1, count rate; DIV = CLK_HZ/TICK_HZ, must be an integer >= 2.
- WRAP, 1, up-count at 99:59: 1 = wrap to 00:00, 0 = saturate at 99:59.

Ports:
- clk  in  1  system clock; all logic is posedge.
- rst  in  1  asynchronous, active-high reset.
- clr  in  1  synchronous clear of count and prescaler.
- run  in  1  1 = counting, 0 = paused.
- dir  in  1  0 = count up, 1 = count down.
- ld  in  1  load strobe for one digit.
- ld_sel  in  2  digit select: 0 = min_l, 1 = min_r, 2 = sec_l, 3 = sec_r.
- ld_val  in  4  BCD value to load.
- min_l, min_r, sec_l, sec_r  out  4 each  BCD digits.
- tick  out  1  one-cycle pulse on every count step actually applied.
- zero  out  1  level; high when the display reads 00:00.
- done  out  1  one-cycle pulse when a down-count reaches 00:00.
- ovf  out  1  one-cycle pulse on an up-count step taken at 99:59.

Behaviour:
- Reset values: rst asserted drives all digits, the prescaler, tick, done and ovf to 0, and zero to 1. These values hold until the first clk edge after rst deasserts.
- Priority per cycle: rst > clr > ld > count step.
- Prescaler:
  - Counts 0..DIV-1 while run=1. It holds its value while run=0, so pausing does not lose partial time.
  - On clr it returns to 0.
  - Step condition: prescaler == DIV-1 and run=1. The prescaler rolls to 0 on that cycle.
- Step latency: digits and tick update on the clk edge that samples the step condition. Outputs are registered with no combinational path from inputs.
- Up step:
  - sec_r+1; at 10 it becomes 0 and carries to sec_l.
  - sec_l at 6 becomes 0 and carries to min_r.
  - min_r at 10 becomes 0 and carries to min_l.
  - Step from 99:59: with WRAP=1 the count goes to 00:00 and ovf pulses. With WRAP=0 the count holds 99:59, ovf pulses and tick pulses.
- Down step:
  - Borrow chain mirrors the up step: sec_r 0 becomes 9, sec_l 0 becomes 5, min_r 0 becomes 9, each borrowing from the next digit.
  - Step to 00:00 pulses done together with tick.
  - At 00:00 down steps are suppressed: count holds, no tick, no further done.
- ld:
  - Writes ld_val to the selected digit with clamping: sec_l values above 5 load 5; other digits' values above 9 load 9.
  - The prescaler is not disturbed.
  - A step due in the same cycle is dropped; the prescaler still rolls.
- clr: digits go to 0 and the prescaler goes to 0; no done or ovf pulse.
- dir change: takes effect on the next step. A change mid-interval does not reset the prescaler.
- zero is registered and reflects the digits after the same edge.
- rst asserted mid-interval aborts immediately. Any pulse that would have occurred is lost.

Decomposition:
- Package mmss_pkg:
  - bcd_t (4-bit digit)
  - SEL_MIN_L, SEL_MIN_R, SEL_SEC_L, SEL_SEC_R
  - SEC_L_MAX=5, DIGIT_MAX=9
  - a digit-clamp function
- Sub-module tick_prescaler:
  - Parameter DIV.
  - Ports clk, rst, clr, en.
  - Output step (1-cycle pulse).
  - Reused by the display scan and blink logic.

Test Plan (CLK_HZ=10, TICK_HZ=1, so DIV=10):
- rst, then run=1, dir=0 for 600 clocks -> digits step every 10 clocks; reading 01:00 after 600 clocks; 60 tick pulses.
- Load 9,9,5,9 into min_l..sec_r, dir=0, WRAP=1, run 10 clocks -> 00:00, one ovf pulse, zero=1. Repeat with WRAP=0 -> holds 99:59, ovf pulses.
- Load 00:02, dir=1, run 30 clocks -> 00:01 at clock 10, 00:00 with a single done at clock 20, no tick/done at clock 30, zero=1.
- Run for 4 clocks, run=0 for 50 clocks, run=1 -> first step 6 clocks after resume; digits frozen during the pause.
- ld_sel=2, ld_val=8 -> sec_l=5; ld_sel=0, ld_val=12 -> min_l=9. Raise ld in a step cycle -> loaded value wins, no tick.
- Assert rst asynchronously mid-interval at 12:34 -> digits read 0 before the next clk edge; clr at 05:00 -> 00:00 with no done pulse.
